// File: rtl/dot_product_mac_pkg.sv
// Shared constants and FSM encoding for the dot-product MAC stage.
package dot_product_mac_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BITS_COMP  = 4;

    // Default accumulator width: wide enough that Nums_Computation full-scale products never overflow.
    function automatic int acc_width(input int dw, input int bc);
        return 2 * dw + bc;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_product_mac_mac_pipe.sv
// Strobe -> product -> accumulate pipeline for the dot-product MAC.
// SIGNED_OPERANDS_EN selects two's-complement operands; default is unsigned.
module mac_pipe
    import dot_product_mac_pkg::*;
#(
    parameter int Data_Width       = DATA_WIDTH,
    parameter int bits_Computation = BITS_COMP,
    parameter int Acc_Width        = acc_width(DATA_WIDTH, BITS_COMP)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        flush,
    input  logic                        strobe,
    input  logic [Data_Width-1:0]       data_a,
    input  logic [Data_Width-1:0]       data_b,
    output logic [Acc_Width-1:0]        acc_nxt,
    output logic                        elem_vld,
    output logic [bits_Computation:0]   elem_count
);

    localparam int PW = 2 * Data_Width;
    localparam int CW = bits_Computation + 1;
    localparam logic [CW-1:0] NUM = CW'(1 << bits_Computation);

    logic [CW-1:0]        issue_cnt;
    logic                 rd_vld_d, prod_vld, accept, sx;
    logic [PW-1:0]        op_a, op_b, prod_full, prod_q;
    logic [Acc_Width-1:0] prod_ext, acc;

`ifdef SIGNED_OPERANDS_EN
    assign op_a = {{Data_Width{data_a[Data_Width-1]}}, data_a};
    assign op_b = {{Data_Width{data_b[Data_Width-1]}}, data_b};
    assign sx   = prod_q[PW-1];
`else
    assign op_a = {{Data_Width{1'b0}}, data_a};
    assign op_b = {{Data_Width{1'b0}}, data_b};
    assign sx   = 1'b0;
`endif

    // Low 2*Data_Width bits of the extended product are exact in both builds.
    assign prod_full = op_a * op_b;

    if (Acc_Width > PW) begin : g_ext
        assign prod_ext = {{(Acc_Width-PW){sx}}, prod_q};
    end else begin : g_trunc
        assign prod_ext = prod_q[Acc_Width-1:0];
    end

    // Cap issued strobes so late strobes never reach the accumulator.
    assign accept   = strobe && !flush && (issue_cnt != NUM);
    assign elem_vld = prod_vld && !flush;
    assign acc_nxt  = acc + prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_d   <= 1'b0;
            prod_vld   <= 1'b0;
            prod_q     <= '0;
            acc        <= '0;
            elem_count <= '0;
            issue_cnt  <= '0;
        end else begin
            rd_vld_d <= accept;
            prod_vld <= rd_vld_d && !flush;
            if (rd_vld_d)
                prod_q <= prod_full;
            if (clear) begin
                acc        <= '0;
                elem_count <= '0;
                issue_cnt  <= '0;
            end else begin
                if (accept)
                    issue_cnt <= issue_cnt + CW'(1);
                if (elem_vld) begin
                    acc <= acc_nxt;
                    if (elem_count != NUM)
                        elem_count <= elem_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dot_product_mac.sv
// Dot-product MAC: job FSM, result registers and result-SRAM write port around mac_pipe.
// Optional macro SIGNED_OPERANDS_EN switches operands/result to two's complement.
module dot_product_mac
    import dot_product_mac_pkg::*;
#(
    parameter int Data_Width       = DATA_WIDTH,
    parameter int bits_Computation = BITS_COMP,
    parameter int Nums_Computation = 1 << bits_Computation,
    parameter int Addr_Width       = 4,
    parameter int Acc_Width        = acc_width(Data_Width, bits_Computation)
) (
    input  logic                        clk,
    input  logic                        Comp_reset_n,
    input  logic                        Computing,
    input  logic                        En_Read_A,
    input  logic [Data_Width-1:0]       Data_A,
    input  logic [Data_Width-1:0]       Data_B,
    output logic [Acc_Width-1:0]        Result,
    output logic                        Result_Valid,
    output logic                        Wr_En,
    output logic [Addr_Width-1:0]       Wr_Addr,
    output logic [Acc_Width-1:0]        Wr_Data,
    output logic                        Busy,
    output logic [bits_Computation:0]   Elem_Count
);

    localparam int CW = bits_Computation + 1;
    localparam logic [CW-1:0] LAST = CW'(Nums_Computation - 1);

    state_t                 state_q, state_d;
    logic                   clear, flush, busy, done_load, last_elem, elem_vld, result_valid_q;
    logic [Acc_Width-1:0]   acc_nxt, result_q;
    logic [Addr_Width-1:0]  wr_addr_q;
    logic [CW-1:0]          elem_count;

    mac_pipe #(
        .Data_Width       (Data_Width),
        .bits_Computation (bits_Computation),
        .Acc_Width        (Acc_Width)
    ) u_mac_pipe (
        .clk        (clk),
        .rst_n      (Comp_reset_n),
        .clear      (clear),
        .flush      (flush),
        .strobe     (En_Read_A),
        .data_a     (Data_A),
        .data_b     (Data_B),
        .acc_nxt    (acc_nxt),
        .elem_vld   (elem_vld),
        .elem_count (elem_count)
    );

    assign last_elem = elem_vld && (elem_count == LAST);

    always_ff @(posedge clk or negedge Comp_reset_n) begin
        if (!Comp_reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Abort takes priority over a completion landing on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Computing) state_d = RUN;
            RUN:     if (!Computing) state_d = IDLE;
                     else if (last_elem) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (!Computing) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        clear     = 1'b0;
        flush     = 1'b1;
        done_load = 1'b0;
        case (state_q)
            IDLE:  clear = Computing;
            RUN: begin
                busy      = 1'b1;
                flush     = !Computing;
                done_load = Computing && last_elem;
            end
            DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Result is captured with the final element so the write pulse lines up with DRAIN.
    always_ff @(posedge clk or negedge Comp_reset_n) begin
        if (!Comp_reset_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            wr_addr_q      <= '0;
        end else begin
            result_valid_q <= done_load;
            if (done_load)
                result_q <= acc_nxt;
            if (result_valid_q)
                wr_addr_q <= wr_addr_q + Addr_Width'(1);
        end
    end

    assign Result       = result_q;
    assign Wr_Data      = result_q;
    assign Result_Valid = result_valid_q;
    assign Wr_En        = result_valid_q;
    assign Wr_Addr      = wr_addr_q;
    assign Busy         = busy;
    assign Elem_Count   = elem_count;

endmodule

// File: tb/tb_dot_product_mac.sv
// Scoreboard bench for dot_product_mac: expected results queued at stimulus, popped on Result_Valid.
module tb_dot_product_mac;

    logic        clk, Comp_reset_n, Computing, En_Read_A;
    logic [7:0]  Data_A, Data_B;
    logic [19:0] Result, Wr_Data;
    logic        Result_Valid, Wr_En, Busy;
    logic [3:0]  Wr_Addr;
    logic [4:0]  Elem_Count;

    dot_product_mac dut (
        .clk          (clk),
        .Comp_reset_n (Comp_reset_n),
        .Computing    (Computing),
        .En_Read_A    (En_Read_A),
        .Data_A       (Data_A),
        .Data_B       (Data_B),
        .Result       (Result),
        .Result_Valid (Result_Valid),
        .Wr_En        (Wr_En),
        .Wr_Addr      (Wr_Addr),
        .Wr_Data      (Wr_Data),
        .Busy         (Busy),
        .Elem_Count   (Elem_Count)
    );

    typedef struct {
        logic [19:0] res;
        logic [3:0]  addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_chk = 0, n_fail = 0;
    logic [3:0]  addr_model = '0;
    logic [19:0] prev_res = '0;
    logic [7:0]  ta[16], tb[16];
    logic        pend_v = 1'b0;
    logic [7:0]  pend_a, pend_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_OPERANDS_EN
        return int'($signed(a)) * int'($signed(b));
`else
        return int'(a) * int'(b);
`endif
    endfunction

    // Read data follows its strobe by one cycle; unstrobed cycles carry garbage.
    task automatic drive_cycle(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        Data_A    = pend_v ? pend_a : 8'($urandom);
        Data_B    = pend_v ? pend_b : 8'($urandom);
        En_Read_A = s;
        pend_v = s;
        pend_a = a;
        pend_b = b;
    endtask

    task automatic start_job();
        drive_cycle(0, 0, 0);
        Computing = 1'b1;
        drive_cycle(0, 0, 0);
    endtask

    task automatic job(input int gap, input int extra, input bit chk_busy, input bit chk_lat);
        int   sum;
        exp_t e;
        start_job();
        sum = 0;
        for (int i = 0; i < 16; i++) sum += model_prod(ta[i], tb[i]);
        e.res  = 20'(sum);
        e.addr = addr_model;
        sb.push_back(e);
        addr_model++;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1, ta[i], tb[i]);
            if (chk_busy) chk("busy_run", 32'(Busy), 1);
            for (int g = 0; g < gap; g++) begin
                drive_cycle(0, 0, 0);
                if (chk_busy) chk("busy_gap", 32'(Busy), 1);
            end
        end
        for (int x = 0; x < extra; x++) begin
            drive_cycle(1, 8'hFF, 8'hFF);
            drive_cycle(0, 0, 0);
        end
        if (chk_lat) begin
            drive_cycle(0, 0, 0); chk("valid_lat1", 32'(Result_Valid), 0);
            drive_cycle(0, 0, 0); chk("valid_lat2", 32'(Result_Valid), 0);
            drive_cycle(0, 0, 0); chk("valid_lat3", 32'(Result_Valid), 1);
            drive_cycle(0, 0, 0); chk("valid_lat4", 32'(Result_Valid), 0);
        end
        for (int t = 0; t < 30 && sb.size() != 0; t++) drive_cycle(0, 0, 0);
        chk("timeout_sb_empty", 32'(sb.size()), 0);
        sb.delete();
        drive_cycle(0, 0, 0);
        chk("wr_addr_next", 32'(Wr_Addr), 32'(addr_model));
        chk("elem_count_full", 32'(Elem_Count), 16);
        chk("busy_done", 32'(Busy), 0);
        Computing = 1'b0;
        drive_cycle(0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (Comp_reset_n) begin
            chk("wr_en_eq_valid", 32'(Wr_En), 32'(Result_Valid));
            if (Result_Valid) begin
                chk("busy_drain", 32'(Busy), 1);
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("result", 32'(Result), 32'(e_mon.res));
                    chk("wr_data", 32'(Wr_Data), 32'(e_mon.res));
                    chk("wr_addr", 32'(Wr_Addr), 32'(e_mon.addr));
                    prev_res = e_mon.res;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Comp_reset_n = 1'b0;
        Computing    = 1'b0;
        En_Read_A    = 1'b0;
        Data_A       = '0;
        Data_B       = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", 32'(Result), 0);
        chk("rst_valid", 32'(Result_Valid), 0);
        chk("rst_wr_en", 32'(Wr_En), 0);
        chk("rst_addr", 32'(Wr_Addr), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_count", 32'(Elem_Count), 0);
        Comp_reset_n = 1'b1;

        // A = 1..16, B = 1 -> 136, with latency check
        for (int i = 0; i < 16; i++) begin ta[i] = 8'(i + 1); tb[i] = 8'd1; end
        job(0, 0, 0, 1);

        // full-scale operands -> 1040400
        for (int i = 0; i < 16; i++) begin ta[i] = 8'hFF; tb[i] = 8'hFF; end
        job(0, 0, 0, 0);

        // gapped strobes, extra strobes after the 16th are ignored -> 96
        for (int i = 0; i < 16; i++) begin ta[i] = 8'd2; tb[i] = 8'd3; end
        job(1, 4, 1, 0);

        // abort after 8 pairs
        start_job();
        for (int i = 0; i < 8; i++) drive_cycle(1, 8'd50, 8'd60);
        drive_cycle(0, 0, 0);
        Computing = 1'b0;
        repeat (6) drive_cycle(0, 0, 0);
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_result", 32'(Result), 32'(prev_res));
        chk("abort_addr", 32'(Wr_Addr), 32'(addr_model));
        for (int i = 0; i < 16; i++) begin ta[i] = 8'($urandom); tb[i] = 8'($urandom); end
        job(0, 0, 0, 0);

        // asynchronous reset mid-job
        start_job();
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'd7, 8'd9);
        #2 Comp_reset_n = 1'b0;
        #1;
        chk("arst_result", 32'(Result), 0);
        chk("arst_wr_data", 32'(Wr_Data), 0);
        chk("arst_valid", 32'(Result_Valid), 0);
        chk("arst_busy", 32'(Busy), 0);
        chk("arst_addr", 32'(Wr_Addr), 0);
        chk("arst_count", 32'(Elem_Count), 0);
        sb.delete();
        addr_model = '0;
        prev_res   = '0;
        Computing  = 1'b0;
        En_Read_A  = 1'b0;
        pend_v     = 1'b0;
        @(negedge clk);
        Comp_reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin ta[i] = 8'($urandom); tb[i] = 8'($urandom); end
        job(0, 0, 0, 0);

        // 17 back-to-back jobs: write address wraps through 15 -> 0
        for (int j = 0; j < 17; j++) begin
            for (int i = 0; i < 16; i++) begin ta[i] = 8'($urandom); tb[i] = 8'($urandom); end
            job(0, 0, 0, 0);
        end

        // A = 0xFF, B = 2: -32 signed, 8160 unsigned
        for (int i = 0; i < 16; i++) begin ta[i] = 8'hFF; tb[i] = 8'd2; end
        job(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
